// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD display path.
// Holds FSM encodings, the display blank code and the scratch-width helper.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Decimal digits needed to hold an unsigned w-bit value (77/256 ~ log10(2)).
  function automatic int scr_d(input int w);
    return (w * 77) / 256 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: adds 3 to a BCD digit that is 5 or more.
// Ports: din (4-bit digit), dout (adjusted digit, 4-bit modulo).
module bcd_digit_adj
  import disp_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_display_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the 7-seg display.
// Ports: clk, rst_n (sync, active-low), i_bin, i_start -> o_busy, o_valid, o_bcd, o_ovf.
// Option macro BCD_LZ_BLANK_EN: leading zero digits are output as the blank code 4'hF.
module bcd_display_conv
  import disp_pkg::*;
#(
  parameter int IN_W        = 32,
  parameter int DIGITS      = 8,
  parameter int AUTO_UPDATE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       i_bin,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  localparam int SCR_D = scr_d(IN_W);
  localparam int EXT_D = (SCR_D > DIGITS) ? SCR_D : DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  state_t state, state_nx;

  logic [IN_W-1:0]    sh;
  logic [IN_W-1:0]    last_bin;
  logic [4*SCR_D-1:0] scratch;
  logic [4*SCR_D-1:0] adj;
  logic [CNT_W-1:0]   cnt;

  logic go;
  logic load;
  logic shift_en;
  logic finish;

  logic [4*EXT_D-1:0]  scr_ext;
  logic [4*DIGITS-1:0] bcd_out;
  logic                ovf_out;

  genvar g;
  generate
    for (g = 0; g < SCR_D; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (scratch[4*g +: 4]),
        .dout (adj[4*g +: 4])
      );
    end
  endgenerate

  assign go = i_start |
              ((AUTO_UPDATE != 0) && (i_bin != last_bin));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result shaping: zero-extend so the output slice and the overflow
  // test stay legal for any IN_W/DIGITS combination.
  assign scr_ext = (4*EXT_D)'(scratch);
  assign ovf_out = |(scr_ext >> (4*DIGITS));

  always_comb begin
    bcd_out = scr_ext[4*DIGITS-1:0];
`ifdef BCD_LZ_BLANK_EN
    begin : blank
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead && (bcd_out[4*i +: 4] == 4'h0)) begin
          bcd_out[4*i +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh       <= '0;
      last_bin <= '0;
      scratch  <= '0;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_bcd    <= '0;
      o_ovf    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (load) begin
        sh       <= i_bin;
        last_bin <= i_bin;
        scratch  <= '0;
        cnt      <= '0;
        o_busy   <= 1'b1;
      end
      if (shift_en) begin
        scratch <= {adj[4*SCR_D-2:0], sh[IN_W-1]};
        sh      <= sh << 1;
        cnt     <= cnt + 1'b1;
      end
      if (finish) begin
        o_bcd   <= bcd_out;
        o_ovf   <= ovf_out;
        o_valid <= 1'b1;
        o_busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_conv.sv
// Scoreboard bench for bcd_display_conv.
// Decimal reference model; monitor checks every o_valid against the queue.
module tb_bcd_display_conv;

  localparam int LAT = 33;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_bin;
  logic        i_start;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_bcd;
  logic        o_ovf;

  typedef struct {
    logic [31:0] bin;
    logic [31:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] prev = '0;

  bcd_display_conv #(
    .IN_W        (32),
    .DIGITS      (8),
    .AUTO_UPDATE (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_bin   (i_bin),
    .i_start (i_start),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_bcd   (o_bcd),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference: plain decimal arithmetic on the input value.
  function automatic exp_t model(input logic [31:0] v, input int due);
    exp_t e;
    longint unsigned x;
    int msd;
    x = 64'(v);
    e.bin = v;
    e.bcd = '0;
    msd = 0;
    for (int d = 0; d < 8; d++) begin
      e.bcd[4*d +: 4] = 4'(x % 10);
      if (x % 10 != 0) msd = d;
      x = x / 10;
    end
    e.ovf = (x != 0);
`ifdef BCD_LZ_BLANK_EN
    for (int d = 7; d > msd; d--) e.bcd[4*d +: 4] = 4'hF;
`endif
    e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(o_valid), 64'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("valid_cycle", 64'(cyc), 64'(e.due));
          chk("bcd", 64'(o_bcd), 64'(e.bcd));
          chk("ovf", 64'(o_ovf), 64'(e.ovf));
          chk("busy_at_valid", 64'(o_busy), 64'(0));
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        exp_t e;
        e = q.pop_front();
        chk("missing_valid", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Present v (with optional start) so the next edge accepts it,
  // then hold off until the converter can take another request.
  task automatic issue(input logic [31:0] v, input logic st);
    int e0;
    @(negedge clk);
    if (v == prev) st = 1'b1;
    i_bin   = v;
    i_start = st;
    e0 = cyc + 1;
    q.push_back(model(v, e0 + LAT));
    prev = v;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_go", 64'(o_busy), 64'(1));
    repeat (LAT - 1) @(negedge clk);
    chk("busy_last_shift", 64'(o_busy), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_bin   = '0;
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_bcd", 64'(o_bcd), 64'(0));
    chk("rst_ovf", 64'(o_ovf), 64'(0));
    rst_n = 1'b1;

    issue(32'd0, 1'b1);
    issue(32'd12345678, 1'b1);
    issue(32'hFFFF_FFFF, 1'b1);
    issue(32'd42, 1'b0);
    issue(32'd99999999, 1'b1);
    issue(32'd100000000, 1'b0);

    // Change during a conversion is ignored, then caught in IDLE.
    begin
      int e0;
      @(negedge clk);
      i_bin   = 32'd5;
      i_start = 1'b1;
      e0 = cyc + 1;
      q.push_back(model(32'd5, e0 + LAT));
      @(negedge clk);
      i_start = 1'b0;
      repeat (9) @(negedge clk);
      i_bin   = 32'd7;
      i_start = 1'b1;
      q.push_back(model(32'd7, e0 + LAT + 1 + LAT));
      @(negedge clk);
      i_start = 1'b0;
      repeat (e0 + 2*LAT + 1 - cyc) @(negedge clk);
      prev = 32'd7;
    end

    // Reset mid-conversion aborts with no valid pulse.
    @(negedge clk);
    i_bin   = 32'd999;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    i_bin = '0;
    @(negedge clk);
    chk("abort_busy", 64'(o_busy), 64'(0));
    chk("abort_bcd", 64'(o_bcd), 64'(0));
    chk("abort_ovf", 64'(o_ovf), 64'(0));
    chk("abort_valid", 64'(o_valid), 64'(0));
    rst_n = 1'b1;
    prev  = '0;
    repeat (40) @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] v;
      unique case (n % 4)
        0: v = $urandom % 10;
        1: v = $urandom % 100000;
        2: v = $urandom % 100000000;
        default: v = $urandom;
      endcase
      issue(v, 1'($urandom % 2));
    end

    for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
